// File: rtl/lsu_unit.sv
// RV32 load/store unit: one data-memory transaction at a time, with lane
// steering, load extension, misalignment checks and a bus timeout.
module lsu_unit #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        done,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err_misalign,
    output logic        err_bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic        st_q, st_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] sd_q, sd_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        emis_q, emis_d;
    logic        ebus_q, ebus_d;

    logic        legal;
    logic        misal;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_ext;
    logic [3:0]  strb;
    logic [31:0] wdat;
    logic        is_req;
    logic        is_resp;
    logic        any_err;

    always_comb begin
        legal = 1'b0;
        if (is_store) begin
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                    (funct3 == 3'b010);
        end else begin
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                    (funct3 == 3'b010) || (funct3 == 3'b100) ||
                    (funct3 == 3'b101);
        end
        misal = ((funct3[1:0] == 2'b01) && addr[0]) ||
                ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    end

    // Lane selection uses the registered address; rdata is not yet captured
    assign ld_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign ld_h = mem_rdata[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        ld_ext = mem_rdata;
        unique case (f3_q)
            3'b000:  ld_ext = {{24{ld_b[7]}}, ld_b};
            3'b100:  ld_ext = {24'd0, ld_b};
            3'b001:  ld_ext = {{16{ld_h[15]}}, ld_h};
            3'b101:  ld_ext = {16'd0, ld_h};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        strb = 4'b1111;
        wdat = sd_q;
        unique case (f3_q[1:0])
            2'b00: begin
                strb = 4'b0001 << addr_q[1:0];
                wdat = {4{sd_q[7:0]}};
            end
            2'b01: begin
                strb = 4'b0011 << addr_q[1:0];
                wdat = {2{sd_q[15:0]}};
            end
            default: begin
                strb = 4'b1111;
                wdat = sd_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        sd_d    = sd_q;
        rd_d    = rd_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        emis_d  = emis_q;
        ebus_d  = ebus_q;
        unique case (state_q)
            S_IDLE: begin
                if (ex_valid) begin
                    st_d    = is_store;
                    f3_d    = funct3;
                    addr_d  = addr;
                    sd_d    = store_data;
                    rd_d    = rd_in;
                    data_d  = 32'd0;
                    ebus_d  = 1'b0;
                    emis_d  = !legal || misal;
                    state_d = (!legal || misal) ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    cnt_d   = '0;
                    state_d = st_q ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                // rvalid takes priority over a coincident timeout
                if (mem_rvalid) begin
                    data_d  = ld_ext;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    ebus_d  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            st_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            sd_q    <= 32'd0;
            rd_q    <= 5'd0;
            data_q  <= 32'd0;
            cnt_q   <= '0;
            emis_q  <= 1'b0;
            ebus_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            sd_q    <= sd_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            emis_q  <= emis_d;
            ebus_q  <= ebus_d;
        end
    end

    assign is_req  = (state_q == S_REQ);
    assign is_resp = (state_q == S_RESP);
    assign any_err = emis_q || ebus_q;

    assign ex_ready     = (state_q == S_IDLE);
    assign mem_req      = is_req;
    assign mem_we       = is_req && st_q;
    assign mem_addr     = is_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_wdata    = (is_req && st_q) ? wdat : 32'd0;
    assign mem_wstrb    = (is_req && st_q) ? strb : 4'b0000;
    assign done         = is_resp;
    assign wb_we        = is_resp && !st_q && !any_err;
    assign wb_rd        = rd_q;
    assign wb_data      = (is_resp && !any_err) ? data_q : 32'd0;
    assign err_misalign = is_resp && emis_q;
    assign err_bus      = is_resp && ebus_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Randomized self-checking bench for lsu_unit against a behavioural model
// of RV32 load/store lane and extension rules.
module tb_lsu_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        done;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err_misalign;
    logic        err_bus;

    int n_run = 0;
    int n_fail = 0;

    lsu_unit #(.TIMEOUT_CYC(TO), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .is_store(is_store), .funct3(funct3), .addr(addr),
        .store_data(store_data), .rd_in(rd_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .done(done), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .err_misalign(err_misalign), .err_bus(err_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit m_bad(input bit st, input int f3, input int a);
        bit legal;
        int sz;
        sz = f3 % 4;
        if (st) legal = (f3 <= 2);
        else legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        if (!legal) return 1;
        if (sz == 1 && (a % 2) != 0) return 1;
        if (sz == 2 && (a % 4) != 0) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] m_load(input int f3, input int s,
                                           input logic [31:0] rd);
        logic [31:0] v;
        if (f3 == 0 || f3 == 4) begin
            v = (rd >> (8 * s)) & 32'hFF;
            if (f3 == 0 && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (f3 == 1 || f3 == 5) begin
            v = (rd >> (16 * (s / 2))) & 32'hFFFF;
            if (f3 == 1 && v >= 32'h8000) v = v | 32'hFFFF0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_strb(input int f3, input int s);
        if (f3 == 0) return 32'(1 << s);
        if (f3 == 1) return 32'(3 << s);
        return 32'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input int f3,
                                            input logic [31:0] sd);
        if (f3 == 0) return (sd & 32'hFF) * 32'h01010101;
        if (f3 == 1) return (sd & 32'hFFFF) * 32'h00010001;
        return sd;
    endfunction

    // One full transaction with gnt after gd cycles and rvalid on WAIT cycle rvd
    task automatic do_op(input bit st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] rd, input int gd, input int rvd,
                         input logic [31:0] rdat, input bit junk);
        bit bad;
        int lat;
        int k;
        int nreq;
        int s;
        int exp_k;
        bit ebus;
        bad = m_bad(st, int'(f3), int'(a));
        s = int'(a[1:0]);
        chk("ready_idle", 32'(ex_ready), 32'd1);
        ex_valid = 1'b1;
        is_store = st;
        funct3 = f3;
        addr = a;
        store_data = sd;
        rd_in = rd;
        @(negedge clk);
        ex_valid = 1'b0;
        is_store = $urandom;
        addr = $urandom;
        lat = 1;
        nreq = 0;
        ebus = 0;
        if (!bad) begin
            for (int c = 0; c <= gd; c++) begin
                nreq += int'(mem_req);
                chk("req_addr", mem_addr, a & 32'hFFFFFFFC);
                chk("req_we", 32'(mem_we), 32'(st));
                chk("req_strb", 32'(mem_wstrb), st ? m_strb(f3, s) : 32'd0);
                if (st) chk("req_wdata", mem_wdata, m_wdata(f3, sd));
                mem_gnt = (c == gd);
                mem_rvalid = (c == gd) && junk;
                mem_rdata = $urandom;
                @(negedge clk);
                lat++;
            end
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (!st) begin
                k = 0;
                while (!done && k < 50) begin
                    nreq += int'(mem_req);
                    mem_rvalid = (k == rvd);
                    mem_rdata = (k == rvd) ? rdat : 32'($urandom);
                    @(negedge clk);
                    mem_rvalid = 1'b0;
                    lat++;
                    k++;
                end
                exp_k = (rvd < TO - 1 ? rvd : TO - 1) + 1;
                ebus = (rvd >= TO);
                chk("wait_cycles", 32'(k), 32'(exp_k));
            end
        end
        chk("req_cycles", 32'(nreq), bad ? 32'd0 : 32'(gd + 1));
        chk("latency", 32'(lat), bad ? 32'd1 : 32'(st ? gd + 2 : gd + 2 + exp_k));
        chk("done", 32'(done), 32'd1);
        chk("resp_req", 32'(mem_req), 32'd0);
        chk("err_mis", 32'(err_misalign), 32'(bad));
        chk("err_bus", 32'(err_bus), 32'(ebus));
        chk("wb_we", 32'(wb_we), 32'(!st && !bad && !ebus));
        chk("wb_data", wb_data,
            (st || bad || ebus) ? 32'd0 : m_load(int'(f3), s, rdat));
        if (!st && !bad && !ebus) chk("wb_rd", 32'(wb_rd), 32'(rd));
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        #1;
        chk("rst_ready", 32'(ex_ready), 32'd1);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out", {wb_data[31:6] | mem_addr[31:6], mem_wstrb,
                        wb_we, err_bus}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(0, 3'b010, 32'h100, 0, 5'd3, 0, 0, 32'hDEADBEEF, 0);
        do_op(0, 3'b000, 32'h103, 0, 5'd4, 0, 0, 32'h80FF0000, 0);
        do_op(0, 3'b100, 32'h103, 0, 5'd5, 0, 0, 32'h80FF0000, 0);
        do_op(0, 3'b001, 32'h102, 0, 5'd6, 1, 2, 32'h80FF0000, 1);
        do_op(1, 3'b000, 32'h201, 32'hA5, 5'd7, 3, 0, 0, 0);
        do_op(1, 3'b010, 32'h202, 32'h1234, 5'd8, 0, 0, 0, 0);
        do_op(0, 3'b011, 32'h100, 0, 5'd9, 0, 0, 0, 0);
        do_op(0, 3'b010, 32'h300, 0, 5'd10, 0, 99, 32'h1, 0);
        do_op(0, 3'b101, 32'h302, 0, 5'd11, 0, TO - 1, 32'hF00D8001, 0);

        // Reset during WAIT drops the load; a late rvalid is ignored
        ex_valid = 1'b1;
        is_store = 1'b0;
        funct3 = 3'b010;
        addr = 32'h400;
        @(negedge clk);
        ex_valid = 1'b0;
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(ex_ready), 32'd1);
        chk("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("late_rv_done", 32'(done), 32'd0);
        chk("late_rv_ready", 32'(ex_ready), 32'd1);
        do_op(0, 3'b010, 32'h404, 0, 5'd12, 0, 0, 32'h13572468, 0);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            do_op(1'($urandom), 3'($urandom), a, $urandom, 5'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 5), $urandom,
                  1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
